// File: rtl/iir_deconv.sv
// Streaming inverse of the first-order IIR y[n] = floor(y[n-1]/2) + 4*x[n] (mod 2^YW).
// Optional saturating error counter on port err_cnt when IIR_DECONV_ERRCNT_EN is defined.
module iir_deconv #(
  parameter int YW = 10,
  parameter int XW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [YW-1:0] y_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [XW-1:0] x_out,
  output logic          err_out,
  output logic          out_valid,
  input  logic          out_ready
`ifdef IIR_DECONV_ERRCNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  function automatic logic [YW-1:0] wrap_sub(input logic [YW-1:0] a, input logic [YW-1:0] b);
    return a - b;
  endfunction

  logic [YW-1:0] y_prev_q, y_prev_d;
  logic [YW-1:0] y_base, resid;
  logic [XW-1:0] x_q, x_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic          accept;
  logic          resid_bad;

  assign in_ready  = !vld_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign x_out     = x_q;
  assign err_out   = err_q;
  assign out_valid = vld_q;

  // A clear coinciding with an accept reconstructs against an empty history.
  always_comb begin
    y_base    = clear ? '0 : y_prev_q;
    resid     = wrap_sub(y_in, y_base >> 1);
    resid_bad = |resid[1:0];
    y_prev_d  = y_prev_q;
    x_d       = x_q;
    err_d     = err_q;
    vld_d     = vld_q;
    if (accept) begin
      y_prev_d = y_in;
      x_d      = resid[XW+1:2];
      err_d    = resid_bad;
      vld_d    = 1'b1;
    end else begin
      if (clear)     y_prev_d = '0;
      if (out_ready) vld_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_prev_q <= '0;
      x_q      <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      y_prev_q <= y_prev_d;
      x_q      <= x_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
    end
  end

`ifdef IIR_DECONV_ERRCNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] err_cnt_q, err_cnt_d;

  // Counter survives clear; only reset zeroes it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && resid_bad) err_cnt_d = sat_inc(err_cnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_iir_deconv.sv
// Self-checking bench for iir_deconv: vector table, hand sequences and a modelled random stream.
module tb_iir_deconv;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [9:0] y_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_out;
  logic       err_out;
  logic       out_valid;
  logic       out_ready;
`ifdef IIR_DECONV_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] x;
    logic       e;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [9:0] y;
    logic       clr;
    logic [7:0] ex;
    logic       ee;
  } vec_t;
  vec_t tbl[10];

  iir_deconv #(.YW(10), .XW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .y_in     (y_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_out    (x_out),
    .err_out  (err_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef IIR_DECONV_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Output handshake completes at the next rising edge; compare against the scoreboard.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("x_out", int'(x_out), int'(e.x));
        chk("err_out", int'(err_out), int'(e.e));
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic drive(input logic [9:0] y, input logic clr, input logic [7:0] ex, input logic ee);
    int n;
    exp_t e;
    n = 0;
    y_in = y;
    clear = clr;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      clear = 1'b0;
      return;
    end
    e.x = ex;
    e.e = ee;
    sb.push_back(e);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    clear = 1'b0;
    chk("vld_after_accept", int'(out_valid), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    sb.delete();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_x_out", int'(x_out), 0);
    chk("rst_err_out", int'(err_out), 0);
`ifdef IIR_DECONV_ERRCNT_EN
    chk("rst_err_cnt", int'(err_cnt), 0);
`endif
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] yp, base, r, ry;
    logic       rc;

    tbl[0] = '{10'd508,  1'b0, 8'd127, 1'b0};
    tbl[1] = '{10'd254,  1'b0, 8'd0,   1'b0};
    tbl[2] = '{10'd127,  1'b0, 8'd0,   1'b0};
    tbl[3] = '{10'd63,   1'b0, 8'd0,   1'b0};
    tbl[4] = '{10'd31,   1'b0, 8'd0,   1'b0};
    tbl[5] = '{10'd1020, 1'b1, 8'd255, 1'b0};
    tbl[6] = '{10'd506,  1'b0, 8'd255, 1'b0};
    tbl[7] = '{10'd509,  1'b1, 8'd127, 1'b1};
    tbl[8] = '{10'd254,  1'b0, 8'd0,   1'b0};
    tbl[9] = '{10'd508,  1'b1, 8'd127, 1'b0};

    clear = 1'b0;
    y_in = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    do_reset();

    // Back-to-back stream: impulse, wrap-around, illegal sample, clear-with-accept.
    for (int i = 0; i < 10; i++) drive(tbl[i].y, tbl[i].clr, tbl[i].ex, tbl[i].ee);

    // Clear alone between two identical samples.
    drive(10'd508, 1'b0, 8'd63, 1'b1);
    clear = 1'b1;
    @(posedge clk);
    #2;
    clear = 1'b0;
    drive(10'd508, 1'b0, 8'd127, 1'b0);

    // Backpressure hold, then drain and accept on the same edge.
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    drive(10'd508, 1'b1, 8'd127, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_x_hold", int'(x_out), 127);
      chk("bp_vld_hold", int'(out_valid), 1);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    drive(10'd254, 1'b0, 8'd0, 1'b0);
    chk("bp_x_new", int'(x_out), 0);

    // Illegal sample and error counter after a fresh reset.
    @(posedge clk);
    #2;
    do_reset();
    drive(10'd509, 1'b0, 8'd127, 1'b1);
`ifdef IIR_DECONV_ERRCNT_EN
    chk("err_cnt_one", int'(err_cnt), 1);
`endif
    drive(10'd254, 1'b0, 8'd0, 1'b0);
`ifdef IIR_DECONV_ERRCNT_EN
    chk("err_cnt_keep", int'(err_cnt), 1);
    for (int i = 0; i < 260; i++) drive(10'd509, 1'b1, 8'd127, 1'b1);
    chk("err_cnt_sat", int'(err_cnt), 255);
    clear = 1'b1;
    @(posedge clk);
    #2;
    clear = 1'b0;
    chk("err_cnt_clear", int'(err_cnt), 255);
`endif

    // Reset mid-stream with a pending output.
    out_ready = 1'b0;
    drive(10'd300, 1'b1, 8'd75, 1'b0);
    do_reset();
    out_ready = 1'b1;
    drive(10'd508, 1'b0, 8'd127, 1'b0);

    // Random stream against a reference model, with random backpressure.
    @(posedge clk);
    #2;
    do_reset();
    yp = '0;
    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      ry = 10'($urandom_range(0, 1023));
      rc = ($urandom_range(0, 7) == 0);
      base = rc ? 10'd0 : yp;
      r = ry - (base >> 1);
      drive(ry, rc, r[9:2], |r[1:0]);
      yp = ry;
    end

    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
